// File: rtl/alloc_req.sv
// Request front-end for the linked-memory allocator: buffers requests, drives at most
// one allocator port per cycle (or a fused ALLOC/FREE), and queues the next-cycle results.
module alloc_req #(
  parameter int DATA_SZ   = 16,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 2,
  parameter int MERGE     = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [1:0]         i_req_op,
  input  logic [DATA_SZ-1:0] i_req_addr,
  input  logic [DATA_SZ-1:0] i_req_data,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [1:0]         o_rsp_op,
  output logic [DATA_SZ-1:0] o_rsp_data,
  output logic               o_alloc,
  output logic               o_free,
  output logic               o_rd,
  output logic               o_wr,
  output logic [DATA_SZ-1:0] o_data,
  output logic [DATA_SZ-1:0] o_addr,
  output logic [DATA_SZ-1:0] o_raddr,
  output logic [DATA_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  input  logic [DATA_SZ-1:0] i_rdata,
  input  logic               i_err,
  output logic               o_err,
  output logic               o_idle
);

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ALLOC = 2'd2,
    OP_FREE  = 2'd3
  } op_e;

  localparam int REQ_AW = $clog2(REQ_DEPTH);
  localparam int REQ_PW = REQ_AW + 1;
  localparam int RSP_AW = $clog2(RSP_DEPTH);
  localparam int RSP_PW = RSP_AW + 1;
  localparam logic [REQ_PW-1:0] REQ_FULL = REQ_PW'(REQ_DEPTH);
  localparam logic [RSP_PW-1:0] RSP_FULL = RSP_PW'(RSP_DEPTH);

  logic [1:0]         req_op_mem   [REQ_DEPTH];
  logic [DATA_SZ-1:0] req_addr_mem [REQ_DEPTH];
  logic [DATA_SZ-1:0] req_data_mem [REQ_DEPTH];
  logic [REQ_PW-1:0]  req_wr_ptr;
  logic [REQ_PW-1:0]  req_rd_ptr;
  logic [REQ_PW-1:0]  req_count;
  logic [REQ_PW-1:0]  req_pop_cnt;
  logic               req_push;

  logic [1:0]         rsp_op_mem   [RSP_DEPTH];
  logic [DATA_SZ-1:0] rsp_data_mem [RSP_DEPTH];
  logic [RSP_PW-1:0]  rsp_wr_ptr;
  logic [RSP_PW-1:0]  rsp_rd_ptr;
  logic [RSP_PW-1:0]  rsp_count;
  logic [RSP_PW-1:0]  rsp_committed;
  logic               rsp_pop;

  logic               err_q;
  logic               inflight_q;
  logic [1:0]         inflight_op_q;

  logic [REQ_AW-1:0]  h0_idx;
  logic [REQ_AW-1:0]  h1_idx;
  logic [1:0]         h0_op;
  logic [1:0]         h1_op;
  logic [DATA_SZ-1:0] h0_addr;
  logic [DATA_SZ-1:0] h1_addr;
  logic [DATA_SZ-1:0] h0_data;
  logic [DATA_SZ-1:0] h1_data;

  logic               issue_en;
  logic               credit_ok;
  logic               merge_ok;
  logic               issue_rsp;
  logic [1:0]         issue_op;

  assign req_count   = req_wr_ptr - req_rd_ptr;
  assign rsp_count   = rsp_wr_ptr - rsp_rd_ptr;
  assign o_req_ready = i_rst_n && !err_q && (req_count != REQ_FULL);
  assign req_push    = i_req_valid && o_req_ready;

  assign h0_idx  = req_rd_ptr[REQ_AW-1:0];
  assign h1_idx  = h0_idx + REQ_AW'(1);
  assign h0_op   = req_op_mem[h0_idx];
  assign h1_op   = req_op_mem[h1_idx];
  assign h0_addr = req_addr_mem[h0_idx];
  assign h1_addr = req_addr_mem[h1_idx];
  assign h0_data = req_data_mem[h0_idx];
  assign h1_data = req_data_mem[h1_idx];

  // A response slot is reserved at issue time, so the in-flight result always has room.
  assign rsp_committed = rsp_count + RSP_PW'(inflight_q);
  assign credit_ok     = rsp_committed < RSP_FULL;
  assign issue_en      = (req_count != '0) && !err_q && !i_err;
  assign merge_ok      = (MERGE != 0) && (req_count >= REQ_PW'(2)) && credit_ok &&
                         (((h0_op == OP_ALLOC) && (h1_op == OP_FREE)) ||
                          ((h0_op == OP_FREE)  && (h1_op == OP_ALLOC)));

  // Issue decode from the FIFO head; every allocator output idles at zero.
  always_comb begin
    o_alloc     = 1'b0;
    o_free      = 1'b0;
    o_rd        = 1'b0;
    o_wr        = 1'b0;
    o_data      = '0;
    o_addr      = '0;
    o_raddr     = '0;
    o_waddr     = '0;
    o_wdata     = '0;
    issue_rsp   = 1'b0;
    issue_op    = OP_READ;
    req_pop_cnt = '0;
    if (issue_en) begin
      if (merge_ok) begin
        o_alloc     = 1'b1;
        o_free      = 1'b1;
        o_data      = (h0_op == OP_ALLOC) ? h0_data : h1_data;
        o_addr      = (h0_op == OP_FREE)  ? h0_addr : h1_addr;
        issue_rsp   = 1'b1;
        issue_op    = OP_ALLOC;
        req_pop_cnt = REQ_PW'(2);
      end else begin
        case (h0_op)
          OP_READ: begin
            if (credit_ok) begin
              o_rd        = 1'b1;
              o_raddr     = h0_addr;
              issue_rsp   = 1'b1;
              issue_op    = OP_READ;
              req_pop_cnt = REQ_PW'(1);
            end
          end
          OP_WRITE: begin
            o_wr        = 1'b1;
            o_waddr     = h0_addr;
            o_wdata     = h0_data;
            req_pop_cnt = REQ_PW'(1);
          end
          OP_ALLOC: begin
            if (credit_ok) begin
              o_alloc     = 1'b1;
              o_data      = h0_data;
              issue_rsp   = 1'b1;
              issue_op    = OP_ALLOC;
              req_pop_cnt = REQ_PW'(1);
            end
          end
          default: begin
            o_free      = 1'b1;
            o_addr      = h0_addr;
            req_pop_cnt = REQ_PW'(1);
          end
        endcase
      end
    end
  end

  assign o_rsp_valid = (rsp_count != '0);
  assign rsp_pop     = o_rsp_valid && i_rsp_ready;
  assign o_rsp_op    = o_rsp_valid ? rsp_op_mem[rsp_rd_ptr[RSP_AW-1:0]]   : '0;
  assign o_rsp_data  = o_rsp_valid ? rsp_data_mem[rsp_rd_ptr[RSP_AW-1:0]] : '0;
  assign o_err       = err_q;
  assign o_idle      = (req_count == '0) && (rsp_count == '0) && !inflight_q;

  // Pointers, in-flight tracking and the sticky error; the error never blocks capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_wr_ptr    <= '0;
      req_rd_ptr    <= '0;
      rsp_wr_ptr    <= '0;
      rsp_rd_ptr    <= '0;
      inflight_q    <= 1'b0;
      inflight_op_q <= OP_READ;
      err_q         <= 1'b0;
    end else begin
      if (req_push) req_wr_ptr <= req_wr_ptr + REQ_PW'(1);
      req_rd_ptr    <= req_rd_ptr + req_pop_cnt;
      if (inflight_q) rsp_wr_ptr <= rsp_wr_ptr + RSP_PW'(1);
      if (rsp_pop) rsp_rd_ptr <= rsp_rd_ptr + RSP_PW'(1);
      inflight_q    <= issue_rsp;
      inflight_op_q <= issue_op;
      if (i_err) err_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (req_push) begin
      req_op_mem[req_wr_ptr[REQ_AW-1:0]]   <= i_req_op;
      req_addr_mem[req_wr_ptr[REQ_AW-1:0]] <= i_req_addr;
      req_data_mem[req_wr_ptr[REQ_AW-1:0]] <= i_req_data;
    end
    if (inflight_q) begin
      rsp_op_mem[rsp_wr_ptr[RSP_AW-1:0]]   <= inflight_op_q;
      rsp_data_mem[rsp_wr_ptr[RSP_AW-1:0]] <= i_rdata;
    end
  end

endmodule

// File: tb/tb_alloc_req.sv
// Directed bench for alloc_req with a small behavioural allocator answering the strobes
// one cycle later; responses are collected and compared against hand-computed values.
module tb_alloc_req;

  localparam logic [1:0] OPR = 2'd0;
  localparam logic [1:0] OPW = 2'd1;
  localparam logic [1:0] OPA = 2'd2;
  localparam logic [1:0] OPF = 2'd3;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [1:0]  i_req_op;
  logic [15:0] i_req_addr;
  logic [15:0] i_req_data;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [1:0]  o_rsp_op;
  logic [15:0] o_rsp_data;
  logic        o_alloc, o_free, o_rd, o_wr;
  logic [15:0] o_data, o_addr, o_raddr, o_waddr, o_wdata;
  logic [15:0] i_rdata = '0;
  logic        i_err;
  logic        o_err;
  logic        o_idle;

  alloc_req #(.DATA_SZ(16), .REQ_DEPTH(4), .RSP_DEPTH(2), .MERGE(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_op(o_rsp_op), .o_rsp_data(o_rsp_data),
    .o_alloc(o_alloc), .o_free(o_free), .o_rd(o_rd), .o_wr(o_wr),
    .o_data(o_data), .o_addr(o_addr),
    .o_raddr(o_raddr), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .i_rdata(i_rdata), .i_err(i_err), .o_err(o_err), .o_idle(o_idle)
  );

  always #5 i_clk = ~i_clk;

  // Allocator stand-in: unwritten words read as 0xA000|low byte, fresh nodes count up from 0x5000.
  logic [15:0]  amem [256];
  logic [255:0] written  = '0;
  logic [15:0]  next_ptr = 16'h5000;

  always @(posedge i_clk) begin
    if (o_rd)
      i_rdata <= written[o_raddr[7:0]] ? amem[o_raddr[7:0]] : (16'hA000 | {8'h00, o_raddr[7:0]});
    if (o_wr) begin
      amem[o_waddr[7:0]]    <= o_wdata;
      written[o_waddr[7:0]] <= 1'b1;
    end
    if (o_alloc && o_free) begin
      i_rdata              <= o_addr;
      amem[o_addr[7:0]]    <= o_data;
      written[o_addr[7:0]] <= 1'b1;
    end else if (o_alloc) begin
      i_rdata                <= next_ptr;
      amem[next_ptr[7:0]]    <= o_data;
      written[next_ptr[7:0]] <= 1'b1;
      next_ptr               <= next_ptr + 16'd1;
    end
  end

  logic [17:0] got_q [$];
  int rd_cnt = 0, alloc_cnt = 0, free_cnt = 0, merge_cnt = 0, conflict_cnt = 0;
  logic [15:0] merge_addr = '0, merge_data = '0;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_rd) rd_cnt++;
      if (o_alloc) alloc_cnt++;
      if (o_alloc && o_free) begin
        merge_cnt++;
        merge_addr = o_addr;
        merge_data = o_data;
      end else if (o_free) free_cnt++;
      if ((o_alloc || o_free) && (o_rd || o_wr)) conflict_cnt++;
      if (o_rd && o_wr) conflict_cnt++;
      if (o_rsp_valid && i_rsp_ready) got_q.push_back({o_rsp_op, o_rsp_data});
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    bit          has_rsp;
    logic [17:0] exp;
  } vec_t;

  vec_t        vecs [10];
  logic [17:0] exp_q [$];
  int          got_rd = 0;
  int          tests = 0;
  int          fails = 0;
  int          base_rd, base_alloc, base_free, base_merge;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
    int guard = 0;
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_addr  = addr;
    i_req_data  = data;
    while (!o_req_ready && guard < 100) begin
      tick();
      guard++;
    end
    checkOutput("req_accept", {31'd0, o_req_ready}, 32'd1);
    tick();
    i_req_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int cyc = 0;
    while (!o_idle && cyc < 200) begin
      tick();
      cyc++;
    end
    checkOutput({tag, "_idle"}, {31'd0, o_idle}, 32'd1);
  endtask

  task automatic checkResponses(input string tag);
    int base = got_rd;
    checkOutput({tag, "_rsp_count"}, got_q.size() - base, exp_q.size());
    foreach (exp_q[i]) begin
      if (base + i < got_q.size())
        checkOutput($sformatf("%s_rsp%0d", tag, i), {14'd0, got_q[base + i]}, {14'd0, exp_q[i]});
      else begin
        tests++;
        fails++;
        $display("[TB] FAIL %s_rsp%0d: got nothing, expected 0x%0h", tag, i, exp_q[i]);
      end
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{OPA, 16'h0000, 16'h8005, 1'b1, {OPA, 16'h5000}};
    vecs[1] = '{OPA, 16'h0000, 16'h8007, 1'b1, {OPA, 16'h5001}};
    vecs[2] = '{OPW, 16'h5000, 16'h1234, 1'b0, 18'h0};
    vecs[3] = '{OPR, 16'h5000, 16'h0000, 1'b1, {OPR, 16'h1234}};
    vecs[4] = '{OPR, 16'h5001, 16'h0000, 1'b1, {OPR, 16'h8007}};
    vecs[5] = '{OPW, 16'h5020, 16'hBEEF, 1'b0, 18'h0};
    vecs[6] = '{OPR, 16'h5020, 16'h0000, 1'b1, {OPR, 16'hBEEF}};
    vecs[7] = '{OPR, 16'h5030, 16'h0000, 1'b1, {OPR, 16'hA030}};
    vecs[8] = '{OPF, 16'h5001, 16'h0000, 1'b0, 18'h0};
    vecs[9] = '{OPR, 16'h5040, 16'h0000, 1'b1, {OPR, 16'hA040}};

    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    i_req_op    = OPR;
    i_req_addr  = '0;
    i_req_data  = '0;
    i_rsp_ready = 1'b1;
    i_err       = 1'b0;
    tick();
    tick();
    checkOutput("rst_req_ready", {31'd0, o_req_ready}, 32'd0);
    checkOutput("rst_rsp", {13'd0, o_rsp_valid, o_rsp_op, o_rsp_data}, 32'd0);
    checkOutput("rst_idle_err", {30'd0, o_idle, o_err}, 32'd2);
    checkOutput("rst_strobes", {28'd0, o_alloc, o_free, o_rd, o_wr}, 32'd0);
    checkOutput("rst_addr_data", {16'd0, o_data | o_addr | o_raddr | o_waddr | o_wdata}, 32'd0);
    i_rst_n = 1'b1;
    #1;
    checkOutput("post_rst_req_ready", {31'd0, o_req_ready}, 32'd1);

    // Main table: one request per cycle, responses consumed immediately.
    base_alloc = alloc_cnt;
    base_free  = free_cnt;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].data);
      if (vecs[i].has_rsp) exp_q.push_back(vecs[i].exp);
    end
    waitIdle("table");
    checkResponses("table");
    checkOutput("table_alloc_pulses", alloc_cnt - base_alloc, 32'd2);
    checkOutput("table_free_pulses", free_cnt - base_free, 32'd1);

    // WRITE then READ back-to-back: READ result visible two edges after its push.
    applyStimulus(OPW, 16'h5050, 16'h4321);
    i_req_valid = 1'b1;
    i_req_op    = OPR;
    i_req_addr  = 16'h5050;
    tick();
    i_req_valid = 1'b0;
    @(negedge i_clk);
    checkOutput("lat_rd_issue", {15'd0, o_rd, o_raddr}, {15'd0, 1'b1, 16'h5050});
    checkOutput("lat_e1_valid", {31'd0, o_rsp_valid}, 32'd0);
    @(negedge i_clk);
    checkOutput("lat_e2_valid", {31'd0, o_rsp_valid}, 32'd0);
    @(negedge i_clk);
    checkOutput("lat_e3_rsp", {13'd0, o_rsp_valid, o_rsp_op, o_rsp_data}, {13'd0, 1'b1, OPR, 16'h4321});
    exp_q.push_back({OPR, 16'h4321});
    waitIdle("latency");
    checkResponses("latency");

    // Backpressure: two READs fill the response credits, four more fill the request FIFO.
    i_rsp_ready = 1'b0;
    base_rd = rd_cnt;
    for (int i = 0; i < 6; i++) applyStimulus(OPR, 16'h5060 + 16'(i), 16'h0);
    tick();
    tick();
    tick();
    checkOutput("bp_req_ready", {31'd0, o_req_ready}, 32'd0);
    checkOutput("bp_reads_issued", rd_cnt - base_rd, 32'd2);
    checkOutput("bp_rsp_hold", {13'd0, o_rsp_valid, o_rsp_op, o_rsp_data}, {13'd0, 1'b1, OPR, 16'hA060});
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back({OPR, 16'hA060 + 16'(i)});
    waitIdle("bp");
    checkResponses("bp");
    checkOutput("bp_reads_total", rd_cnt - base_rd, 32'd6);

    // Merge: FREE+ALLOC sit behind a credit-blocked READ and fuse once credit returns.
    i_rsp_ready = 1'b0;
    base_rd    = rd_cnt;
    base_merge = merge_cnt;
    base_free  = free_cnt;
    applyStimulus(OPR, 16'h5070, 16'h0);
    applyStimulus(OPR, 16'h5071, 16'h0);
    applyStimulus(OPR, 16'h5072, 16'h0);
    applyStimulus(OPF, 16'h5000, 16'h0);
    applyStimulus(OPA, 16'h0000, 16'h8009);
    tick();
    tick();
    tick();
    checkOutput("mg_blocked_reads", rd_cnt - base_rd, 32'd2);
    checkOutput("mg_not_yet", merge_cnt - base_merge, 32'd0);
    i_rsp_ready = 1'b1;
    exp_q.push_back({OPR, 16'hA070});
    exp_q.push_back({OPR, 16'hA071});
    exp_q.push_back({OPR, 16'hA072});
    exp_q.push_back({OPA, 16'h5000});
    waitIdle("merge");
    checkResponses("merge");
    checkOutput("mg_count", merge_cnt - base_merge, 32'd1);
    checkOutput("mg_addr_data", {merge_addr, merge_data}, {16'h5000, 16'h8009});
    checkOutput("mg_no_lone_free", free_cnt - base_free, 32'd0);
    applyStimulus(OPR, 16'h5000, 16'h0);
    exp_q.push_back({OPR, 16'h8009});
    waitIdle("merge_rd");
    checkResponses("merge_rd");

    // Error: i_err lands while READ c is in flight with d, e still queued.
    i_rsp_ready = 1'b0;
    base_rd = rd_cnt;
    for (int i = 0; i < 5; i++) applyStimulus(OPR, 16'h5080 + 16'(i), 16'h0);
    i_rsp_ready = 1'b1;
    tick();
    tick();
    i_err = 1'b1;
    tick();
    i_err = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("err_sticky", {31'd0, o_err}, 32'd1);
    checkOutput("err_req_ready", {31'd0, o_req_ready}, 32'd0);
    checkOutput("err_reads", rd_cnt - base_rd, 32'd3);
    checkOutput("err_not_idle", {31'd0, o_idle}, 32'd0);
    exp_q.push_back({OPR, 16'hA080});
    exp_q.push_back({OPR, 16'hA081});
    exp_q.push_back({OPR, 16'hA082});
    checkResponses("err");

    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    #1;
    checkOutput("err_cleared", {31'd0, o_err}, 32'd0);

    // Asynchronous reset with both FIFOs occupied, then a normal ALLOC afterwards.
    i_rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(OPR, 16'h5090 + 16'(i), 16'h0);
    checkOutput("ar_busy", {30'd0, o_idle, o_rsp_valid}, 32'd1);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("ar_rsp", {13'd0, o_rsp_valid, o_rsp_op, o_rsp_data}, 32'd0);
    checkOutput("ar_idle_ready", {30'd0, o_idle, o_req_ready}, 32'd2);
    checkOutput("ar_strobes", {28'd0, o_alloc, o_free, o_rd, o_wr}, 32'd0);
    tick();
    tick();
    i_rst_n     = 1'b1;
    i_rsp_ready = 1'b1;
    #1;
    got_rd = got_q.size();
    applyStimulus(OPA, 16'h0000, 16'h800A);
    exp_q.push_back({OPA, 16'h5002});
    waitIdle("ar_alloc");
    checkResponses("ar_alloc");

    checkOutput("no_port_conflict", conflict_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
